v_mem_ctrl: RTL and testbench
=============================

Name: v_mem_ctrl

Overview:
- Memory-side sequencer for the vector lane. It drives the lane's load FIFO write side (load_fifo_we, data_from_mem) and store FIFO read side (store_fifo_re, data_to_mem).
- Executes one strided vector load or store of vector_length elements between data memory and the lane FIFOs.
- Sits between the vector control unit (start/done) and the data-memory port.

Parameters:
- DATA_WIDTH, 32, element/memory data width in bits.
- VECTOR_LENGTH, 1024, max elements per command; length ports are $clog2(VECTOR_LENGTH)+1 bits.
- MAX_OUTSTANDING, 4, max granted-but-unreturned load reads. Lane load FIFO almost-full offset must be >= MAX_OUTSTANDING+2.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- reset  input  1  synchronous active-low reset.
- start_i  input  1  command strobe; accepted only when ready_o=1.
- cmd_store_i  input  1  0=load, 1=store; sampled with start_i.
- base_addr_i  input  32  first element byte address; sampled with start_i.
- stride_i  input  32  signed byte stride; sampled with start_i.
- vector_length_i  input  $clog2(VECTOR_LENGTH)+1  element count; sampled with start_i.
- ready_o  output  1  high in IDLE only.
- done_o  output  1  one-cycle pulse on command completion.
- mem_req_o  output  1  memory request.
- mem_we_o  output  1  1=write request.
- mem_addr_o  output  32  request byte address.
- mem_wdata_o  output  DATA_WIDTH  write data.
- mem_gnt_i  input  1  request accepted this cycle.
- mem_rdata_i  input  DATA_WIDTH  read data.
- mem_rvalid_i  input  1  read data valid; in-order, one per granted read.
- load_fifo_we_o  output  1  load FIFO write enable.
- data_from_mem_o  output  DATA_WIDTH  load FIFO write data.
- load_fifo_almostfull_i  input  1  throttle for new read issue.
- store_fifo_re_o  output  1  store FIFO read enable.
- data_to_mem_i  input  DATA_WIDTH  store FIFO data, valid the cycle after store_fifo_re_o.
- store_fifo_empty_i  input  1  store FIFO empty.

Behaviour:
- Reset (reset=0 at an edge): state returns to IDLE, all counters and the outstanding count clear, and every registered output goes to 0 (mem_*, load_fifo_we_o, data_from_mem_o, store_fifo_re_o, done_o).
- ready_o is decoded from state, so it reads 1 from the first edge after reset.
- Reset mid-command aborts the command without done_o. Read responses arriving afterwards in IDLE are dropped (no load_fifo_we_o).
- States: IDLE, LD_ISSUE, LD_DRAIN, ST_FETCH, ST_WAIT, ST_WRITE, DONE.
- IDLE: on start_i, latch the command fields and set addr=base_addr_i.
  - vector_length_i=0: go to DONE, no memory or FIFO access.
  - Otherwise go to LD_ISSUE or ST_FETCH. start_i in any other state is ignored.
- LD_ISSUE: mem_req_o=1, mem_we_o=0 while load_fifo_almostfull_i=0 and outstanding<MAX_OUTSTANDING. Request fields hold stable until mem_gnt_i.
  - On grant: issued+1, outstanding+1, addr+=stride.
  - When issued reaches the length, go to LD_DRAIN.
- Load return: mem_rvalid_i causes load_fifo_we_o=1 and data_from_mem_o=mem_rdata_i on the next cycle (1-cycle registered latency). received+1, outstanding-1.
  - Grant and rvalid in the same cycle leave outstanding unchanged.
- LD_DRAIN: wait until received equals the length, then go to DONE.
- ST_FETCH: when store_fifo_empty_i=0, pulse store_fifo_re_o for one cycle and go to ST_WAIT.
- ST_WAIT: capture data_to_mem_i into mem_wdata_o, then go to ST_WRITE.
- ST_WRITE: mem_req_o=1, mem_we_o=1, held until mem_gnt_i.
  - On grant: count+1, addr+=stride.
  - Go to DONE if count equals the length, else to ST_FETCH.
  - Store throughput is at most 1 element per 3 cycles.
- DONE: done_o=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^32; negative stride uses two's complement and wraps silently.
- Counters are $clog2(VECTOR_LENGTH)+1 bits, so a length of exactly VECTOR_LENGTH is legal.

Optional Feature:
- Macro V_MEM_CTRL_ERR_EN.
- Defined: adds output err_o (1 bit, reset 0), a sticky error flag cleared on an accepted start_i. It is set on:
  - mem_rvalid_i with outstanding=0;
  - mem_rvalid_i outside LD_ISSUE/LD_DRAIN;
  - mem_gnt_i while mem_req_o=0.
- Undefined: err_o port absent; these events are ignored. Stray rvalid still produces no FIFO write.

Test Plan:
- Load, base 0x100, stride 4, len 8, gnt always 1, rvalid 2 cycles after gnt -> addrs 0x100..0x11C in order, 8 load_fifo_we_o pulses with matching data, one done_o.
- Store, base 0x200, stride -8, len 3, FIFO holds A,B,C -> writes (0x200,A), (0x1F8,B), (0x1F0,C), 3 store_fifo_re_o pulses, done_o.
- Load with MAX_OUTSTANDING=4 and rvalid withheld -> exactly 4 grants, then mem_req_o=0. Raising load_fifo_almostfull_i also stalls issue; both resume when cleared.
- len=0 start -> done_o two cycles after start, mem_req_o and FIFO enables never asserted.
- Reset low mid-load with 3 outstanding -> all outputs 0 next cycle, no done_o. Later rvalids produce no load_fifo_we_o; ready_o=1.
- Store with store_fifo_empty_i=1 for 10 cycles and mem_gnt_i delayed 5 cycles -> FSM holds in ST_FETCH, mem request fields stable until grant.

Source files
------------

// File: rtl/v_mem_ctrl.sv
// v_mem_ctrl: memory-side sequencer for one vector lane.
// Runs one strided vector load (memory -> lane load FIFO) or store
// (lane store FIFO -> memory) of up to VECTOR_LENGTH elements per command.
//
// Ports:
//   clk, reset               rising-edge clock, synchronous active-low reset
//   start_i, cmd_store_i     command strobe and direction (0 load, 1 store)
//   base_addr_i, stride_i    first byte address, signed byte stride
//   vector_length_i          element count (0 completes with no access)
//   ready_o, done_o          idle indication, one-cycle completion pulse
//   mem_req_o/we/addr/wdata  memory request, held until mem_gnt_i
//   mem_gnt_i                request accepted this cycle
//   mem_rdata_i/rvalid_i     in-order read returns, one per granted read
//   load_fifo_we_o, data_from_mem_o, load_fifo_almostfull_i
//   store_fifo_re_o, data_to_mem_i, store_fifo_empty_i
//   err_o                    sticky protocol error (only with V_MEM_CTRL_ERR_EN)
//
// Optional feature macro: V_MEM_CTRL_ERR_EN adds the err_o output.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start_i, ready_o high
// LD_ISSUE | issuing read requests, throttled by outstanding/almost-full
// LD_DRAIN | all reads issued, waiting for remaining returns
// ST_FETCH | pop one element from the store FIFO when not empty
// ST_WAIT  | store FIFO data valid, capture it as write data
// ST_WRITE | write request held until granted
// DONE     | pulse completion, then back to IDLE

module v_mem_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int VECTOR_LENGTH   = 1024,
    parameter int MAX_OUTSTANDING = 4,
    localparam int LW = $clog2(VECTOR_LENGTH) + 1
) (
`ifdef V_MEM_CTRL_ERR_EN
    output logic                  err_o,
`endif
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  cmd_store_i,
    input  logic [31:0]           base_addr_i,
    input  logic [31:0]           stride_i,
    input  logic [LW-1:0]         vector_length_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_rvalid_i,
    output logic                  load_fifo_we_o,
    output logic [DATA_WIDTH-1:0] data_from_mem_o,
    input  logic                  load_fifo_almostfull_i,
    output logic                  store_fifo_re_o,
    input  logic [DATA_WIDTH-1:0] data_to_mem_i,
    input  logic                  store_fifo_empty_i
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ISSUE = 3'd1,
        LD_DRAIN = 3'd2,
        ST_FETCH = 3'd3,
        ST_WAIT  = 3'd4,
        ST_WRITE = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_addr;
    logic [31:0]           r_stride;
    logic [LW-1:0]         r_len;
    logic [LW-1:0]         r_issued;      // reads issued, or stores written
    logic [LW-1:0]         r_received;
    logic [OW-1:0]         r_outstanding;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_load_we;
    logic [DATA_WIDTH-1:0] r_load_data;
    logic                  r_done;

    logic w_mem_req;
    logic w_mem_we;
    logic w_store_re;
    logic w_start_acc;
    logic w_in_load;
    logic w_issue_rd;
    logic w_rd_acc;
    logic w_last;

    assign w_start_acc = (r_state == IDLE) && start_i;
    assign w_in_load   = (r_state == LD_ISSUE) || (r_state == LD_DRAIN);
    assign w_last      = ((r_issued + LW'(1)) == r_len);
    assign w_issue_rd  = w_mem_req && mem_gnt_i && !w_mem_we;
    // A return is only meaningful while a load is running and something is
    // actually in flight; anything else (e.g. after an abort) is dropped.
    assign w_rd_acc    = mem_rvalid_i && w_in_load && (r_outstanding != '0);

    always_comb begin
        w_next     = r_state;
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_store_re = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    if (vector_length_i == '0) begin
                        w_next = DONE;
                    end else if (cmd_store_i) begin
                        w_next = ST_FETCH;
                    end else begin
                        w_next = LD_ISSUE;
                    end
                end
            end
            LD_ISSUE: begin
                w_mem_req = !load_fifo_almostfull_i && (r_outstanding < MAX_OUT);
                if (w_mem_req && mem_gnt_i && w_last) begin
                    w_next = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (r_received == r_len) begin
                    w_next = DONE;
                end
            end
            ST_FETCH: begin
                if (!store_fifo_empty_i) begin
                    w_store_re = 1'b1;
                    w_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                if (mem_gnt_i) begin
                    w_next = w_last ? DONE : ST_FETCH;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_addr        <= '0;
            r_stride      <= '0;
            r_len         <= '0;
            r_issued      <= '0;
            r_received    <= '0;
            r_outstanding <= '0;
            r_wdata       <= '0;
            r_load_we     <= 1'b0;
            r_load_data   <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_start_acc) begin
                r_addr     <= base_addr_i;
                r_stride   <= stride_i;
                r_len      <= vector_length_i;
                r_issued   <= '0;
                r_received <= '0;
            end else begin
                if (w_mem_req && mem_gnt_i) begin
                    r_addr   <= r_addr + r_stride;
                    r_issued <= r_issued + LW'(1);
                end
                if (w_rd_acc) begin
                    r_received <= r_received + LW'(1);
                end
            end

            case ({w_issue_rd, w_rd_acc})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            r_load_we <= w_rd_acc;
            if (w_rd_acc) begin
                r_load_data <= mem_rdata_i;
            end

            // Store FIFO data is valid the cycle after the pop.
            if (r_state == ST_WAIT) begin
                r_wdata <= data_to_mem_i;
            end

            r_done <= (r_state == DONE);
        end
    end

`ifdef V_MEM_CTRL_ERR_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (mem_rvalid_i && ((r_outstanding == '0) || !w_in_load))
                     || (mem_gnt_i && !w_mem_req);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_err <= 1'b0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`endif

    assign ready_o         = (r_state == IDLE);
    assign done_o          = r_done;
    assign mem_req_o       = w_mem_req;
    assign mem_we_o        = w_mem_we;
    assign mem_addr_o      = r_addr;
    assign mem_wdata_o     = r_wdata;
    assign load_fifo_we_o  = r_load_we;
    assign data_from_mem_o = r_load_data;
    assign store_fifo_re_o = w_store_re;

endmodule

// File: tb/tb_v_mem_ctrl.sv
// Scoreboard bench for v_mem_ctrl: stimulus pushes expected memory requests,
// load FIFO writes and completions into queues; a monitor pops and compares
// them whenever the DUT presents the corresponding event.
module tb_v_mem_ctrl;

    localparam int DW = 32;
    localparam int VL = 1024;
    localparam int MO = 4;
    localparam int LW = $clog2(VL) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_i = 1'b0;
    logic          cmd_store_i = 1'b0;
    logic [31:0]   base_addr_i = '0;
    logic [31:0]   stride_i = '0;
    logic [LW-1:0] vector_length_i = '0;
    logic          ready_o, done_o, mem_req_o, mem_we_o;
    logic [31:0]   mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_gnt_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_rvalid_i = 1'b0;
    logic          load_fifo_we_o;
    logic [DW-1:0] data_from_mem_o;
    logic          load_fifo_almostfull_i = 1'b0;
    logic          store_fifo_re_o;
    logic [DW-1:0] data_to_mem_i = '0;
    logic          store_fifo_empty_i = 1'b1;
`ifdef V_MEM_CTRL_ERR_EN
    logic          err_o;
`endif

    v_mem_ctrl #(.DATA_WIDTH(DW), .VECTOR_LENGTH(VL), .MAX_OUTSTANDING(MO)) dut (
`ifdef V_MEM_CTRL_ERR_EN
        .err_o                  (err_o),
`endif
        .clk                    (clk),
        .reset                  (reset),
        .start_i                (start_i),
        .cmd_store_i            (cmd_store_i),
        .base_addr_i            (base_addr_i),
        .stride_i               (stride_i),
        .vector_length_i        (vector_length_i),
        .ready_o                (ready_o),
        .done_o                 (done_o),
        .mem_req_o              (mem_req_o),
        .mem_we_o               (mem_we_o),
        .mem_addr_o             (mem_addr_o),
        .mem_wdata_o            (mem_wdata_o),
        .mem_gnt_i              (mem_gnt_i),
        .mem_rdata_i            (mem_rdata_i),
        .mem_rvalid_i           (mem_rvalid_i),
        .load_fifo_we_o         (load_fifo_we_o),
        .data_from_mem_o        (data_from_mem_o),
        .load_fifo_almostfull_i (load_fifo_almostfull_i),
        .store_fifo_re_o        (store_fifo_re_o),
        .data_to_mem_i          (data_to_mem_i),
        .store_fifo_empty_i     (store_fifo_empty_i)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard queues: {we, addr, wdata}
    logic [64:0] exp_req[$];
    logic [31:0] exp_load[$];
    int          exp_done = 0;

    int done_cnt = 0;
    int ld_cnt   = 0;
    int re_cnt   = 0;

    // memory / store FIFO model controls
    int          gnt_delay   = 0;
    int          gnt_limit   = 1000000;
    int          gnt_total   = 0;
    int          req_wait    = 0;
    logic        hold_rv     = 1'b0;
    logic        force_empty = 1'b0;
    int          pend_due[$];
    logic [31:0] pend_data[$];
    logic [31:0] st_fifo[$];

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic miss_evt(input string name, input logic [31:0] act);
        n_vec++;
        n_miss++;
        $display("FAIL %s: got %h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Monitor: samples 1 time unit before each rising edge.
    initial begin : monitor
        logic        p_req, p_gnt, p_we;
        logic [31:0] p_addr, p_wdata;
        logic [64:0] e;
        p_req = 1'b0; p_gnt = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            #4;
            if (reset) begin
                if (mem_req_o && mem_gnt_i) begin
                    if (exp_req.size() == 0) begin
                        miss_evt("unexpected_req", mem_addr_o);
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_we", {31'd0, mem_we_o}, {31'd0, e[64]});
                        chk("req_addr", mem_addr_o, e[63:32]);
                        if (e[64]) chk("req_wdata", mem_wdata_o, e[31:0]);
                    end
                end
                if (load_fifo_we_o) begin
                    ld_cnt++;
                    if (exp_load.size() == 0) miss_evt("unexpected_load_we", data_from_mem_o);
                    else chk("load_data", data_from_mem_o, exp_load.pop_front());
                end
                if (done_o) begin
                    done_cnt++;
                    if (exp_done == 0) miss_evt("unexpected_done", 32'd1);
                    else exp_done--;
                end
                if (store_fifo_re_o) re_cnt++;
                if (p_req && !p_gnt && mem_req_o) begin
                    chk("hold_addr", mem_addr_o, p_addr);
                    chk("hold_we", {31'd0, mem_we_o}, {31'd0, p_we});
                    chk("hold_wdata", mem_wdata_o, p_wdata);
                end
            end
            p_req = mem_req_o; p_gnt = mem_gnt_i; p_we = mem_we_o;
            p_addr = mem_addr_o; p_wdata = mem_wdata_o;
        end
    end

    // Memory and store FIFO responder.
    initial begin : responder
        logic [31:0] nxt;
        logic        have_nxt;
        have_nxt = 1'b0;
        nxt = '0;
        forever begin
            @(negedge clk);
            #1;
            if (have_nxt) begin
                data_to_mem_i = nxt;
                have_nxt = 1'b0;
            end
            store_fifo_empty_i = force_empty || (st_fifo.size() == 0);
            #1;
            mem_gnt_i = 1'b0;
            if (mem_req_o && (gnt_total < gnt_limit) && (req_wait >= gnt_delay)) begin
                mem_gnt_i = 1'b1;
                gnt_total++;
                req_wait = 0;
                if (!mem_we_o) begin
                    pend_due.push_back(cyc + 2);
                    pend_data.push_back(rd_data(mem_addr_o));
                end
            end else if (mem_req_o) begin
                req_wait++;
            end else begin
                req_wait = 0;
            end
            mem_rvalid_i = 1'b0;
            if (!hold_rv && (pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i = pend_data.pop_front();
                void'(pend_due.pop_front());
            end
            #1;
            if (store_fifo_re_o && (st_fifo.size() > 0)) begin
                nxt = st_fifo.pop_front();
                have_nxt = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] stride,
                         input int len);
        @(negedge clk);
        start_i = 1'b1;
        cmd_store_i = st;
        base_addr_i = base;
        stride_i = stride;
        vector_length_i = LW'(len);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int lim);
        int k;
        k = 0;
        while ((done_cnt == d0) && (k < lim)) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) miss_evt("done_timeout", 32'(k));
    endtask

    task automatic push_load(input logic [31:0] base, input logic [31:0] stride, input int n);
        logic [31:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_req.push_back({1'b0, a, 32'd0});
            exp_load.push_back(rd_data(a));
            a = a + stride;
        end
    endtask

    initial begin : stim
        int d0, g0, l0, r0;

        // reset state
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_ldwe", {31'd0, load_fifo_we_o}, 32'd0);
        chk("rst_re", {31'd0, store_fifo_re_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_wdata", mem_wdata_o, 32'd0);
        chk("rst_ldata", data_from_mem_o, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // load: base 0x100, stride 4, len 8, immediate grant
        push_load(32'h100, 32'd4, 8);
        exp_done++;
        d0 = done_cnt; l0 = ld_cnt;
        issue(1'b0, 32'h100, 32'd4, 8);
        wait_done(d0, 100);
        chk("t1_loads", 32'(ld_cnt - l0), 32'd8);
        chk("t1_exp_left", 32'(exp_req.size()), 32'd0);
        repeat (2) @(negedge clk);

        // store: base 0x200, stride -8, len 3, data A,B,C
        st_fifo.push_back(32'hAAAA_0001);
        st_fifo.push_back(32'hBBBB_0002);
        st_fifo.push_back(32'hCCCC_0003);
        exp_req.push_back({1'b1, 32'h0000_0200, 32'hAAAA_0001});
        exp_req.push_back({1'b1, 32'h0000_01F8, 32'hBBBB_0002});
        exp_req.push_back({1'b1, 32'h0000_01F0, 32'hCCCC_0003});
        exp_done++;
        d0 = done_cnt; r0 = re_cnt;
        issue(1'b1, 32'h200, 32'hFFFF_FFF8, 3);
        wait_done(d0, 100);
        chk("t2_pops", 32'(re_cnt - r0), 32'd3);
        chk("t2_exp_left", 32'(exp_req.size()), 32'd0);
        repeat (2) @(negedge clk);

        // outstanding limit, then almost-full throttle
        push_load(32'h400, 32'd4, 8);
        exp_done++;
        hold_rv = 1'b1;
        d0 = done_cnt; g0 = gnt_total; l0 = ld_cnt;
        issue(1'b0, 32'h400, 32'd4, 8);
        repeat (8) @(negedge clk);
        #4;
        chk("t3_gnts_cap", 32'(gnt_total - g0), 32'd4);
        chk("t3_req_cap", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        hold_rv = 1'b0;
        @(negedge clk);
        load_fifo_almostfull_i = 1'b1;
        repeat (6) @(negedge clk);
        #4;
        chk("t3_gnts_af", 32'(gnt_total - g0), 32'd4);
        chk("t3_req_af", {31'd0, mem_req_o}, 32'd0);
        chk("t3_loads_af", 32'(ld_cnt - l0), 32'd4);
        @(negedge clk);
        load_fifo_almostfull_i = 1'b0;
        wait_done(d0, 100);
        chk("t3_loads", 32'(ld_cnt - l0), 32'd8);
        repeat (2) @(negedge clk);

        // zero length: done two cycles after start, no access
        exp_done++;
        issue(1'b0, 32'h900, 32'd4, 0);
        #4;
        chk("t4_done_c1", {31'd0, done_o}, 32'd0);
        chk("t4_req_c1", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        #4;
        chk("t4_done_c2", {31'd0, done_o}, 32'd1);
        chk("t4_re_c2", {31'd0, store_fifo_re_o}, 32'd0);
        chk("t4_ldwe_c2", {31'd0, load_fifo_we_o}, 32'd0);
        repeat (2) @(negedge clk);

        // reset mid-load with 3 outstanding
        push_load(32'h800, 32'd4, 3);
        exp_load.delete();
        hold_rv = 1'b1;
        g0 = gnt_total;
        gnt_limit = gnt_total + 3;
        d0 = done_cnt;
        issue(1'b0, 32'h800, 32'd4, 8);
        repeat (8) @(negedge clk);
        #4;
        chk("t5_gnts", 32'(gnt_total - g0), 32'd3);
        chk("t5_req_stall", {31'd0, mem_req_o}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #4;
        chk("t5_rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("t5_rst_addr", mem_addr_o, 32'd0);
        chk("t5_rst_done", {31'd0, done_o}, 32'd0);
        chk("t5_rst_ldwe", {31'd0, load_fifo_we_o}, 32'd0);
        chk("t5_rst_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        hold_rv = 1'b0;
        gnt_limit = 1000000;
        l0 = ld_cnt;
        repeat (8) @(negedge clk);
        #4;
        chk("t5_stray_ldwe", 32'(ld_cnt - l0), 32'd0);
        chk("t5_rv_drained", 32'(pend_due.size()), 32'd0);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);

        // store with FIFO empty for 10 cycles and grant delayed 5 cycles
        st_fifo.push_back(32'hDDDD_0004);
        st_fifo.push_back(32'hEEEE_0005);
        exp_req.push_back({1'b1, 32'h0000_0300, 32'hDDDD_0004});
        exp_req.push_back({1'b1, 32'h0000_0310, 32'hEEEE_0005});
        exp_done++;
        force_empty = 1'b1;
        gnt_delay = 5;
        d0 = done_cnt; r0 = re_cnt;
        issue(1'b1, 32'h300, 32'h10, 2);
        for (int i = 0; i < 10; i++) begin
            #4;
            chk("t6_req_empty", {31'd0, mem_req_o}, 32'd0);
            chk("t6_re_empty", {31'd0, store_fifo_re_o}, 32'd0);
            chk("t6_busy", {31'd0, ready_o}, 32'd0);
            @(negedge clk);
        end
        force_empty = 1'b0;
        wait_done(d0, 100);
        chk("t6_pops", 32'(re_cnt - r0), 32'd2);
        gnt_delay = 0;
        repeat (3) @(negedge clk);

        chk("end_req_left", 32'(exp_req.size()), 32'd0);
        chk("end_load_left", 32'(exp_load.size()), 32'd0);
        chk("end_done_left", 32'(exp_done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
